demux1x2_stripe: RTL and testbench

DEMUX1X2_STRIPE -- requirements
Module: demux1x2_stripe

---
 rtl/demux1x2_stripe.sv | 94 +++++++++
 tb/tb_demux1x2_stripe.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/demux1x2_stripe.sv
// Stripes a byte stream onto two registered lanes, emitting bytes in pairs.
// An unpaired lane-0 byte is flushed alone after FLUSH_CYCLES idle cycles.
module demux1x2_stripe #(
    parameter int FLUSH_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in,
    input  logic       valid_in,
    output logic [7:0] out0,
    output logic [7:0] out1,
    output logic [1:0] valid
);

    typedef enum logic {
        EMPTY = 1'b0,
        HALF  = 1'b1
    } state_t;

    // Idle count already seen when the current idle cycle is the flushing one.
    localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

    state_t     r_state, w_state_nxt;
    logic [7:0] r_hold,  w_hold_nxt;
    logic [3:0] r_idle,  w_idle_nxt;
    logic [7:0] r_out0,  w_out0_nxt;
    logic [7:0] r_out1,  w_out1_nxt;
    logic [1:0] r_valid, w_valid_nxt;

    always_comb begin
        // NOTE: every signal gets a default first, so no path leaves one unassigned and no latch is inferred.
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        w_idle_nxt  = r_idle;
        w_out0_nxt  = r_out0;
        w_out1_nxt  = r_out1;
        w_valid_nxt = 2'b00;

        case (r_state)
            EMPTY: begin
                w_idle_nxt = 4'd0;
                if (valid_in) begin
                    w_hold_nxt  = in;
                    w_state_nxt = HALF;
                end
            end
            HALF: begin
                if (valid_in) begin
                    // Pairing takes precedence over a flush due on the same cycle.
                    w_out0_nxt  = r_hold;
                    w_out1_nxt  = in;
                    w_valid_nxt = 2'b11;
                    w_idle_nxt  = 4'd0;
                    w_state_nxt = EMPTY;
                end else if (r_idle == FLUSH_LAST) begin
                    w_out0_nxt  = r_hold;
                    w_out1_nxt  = 8'h00;
                    w_valid_nxt = 2'b01;
                    w_idle_nxt  = 4'd0;
                    w_state_nxt = EMPTY;
                end else begin
                    w_idle_nxt = r_idle + 4'd1;
                end
            end
            default: begin
                w_state_nxt = EMPTY;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= EMPTY;
            r_hold  <= 8'h00;
            r_idle  <= 4'd0;
            r_out0  <= 8'h00;
            r_out1  <= 8'h00;
            r_valid <= 2'b00;
        end else begin
            r_state <= w_state_nxt;
            r_hold  <= w_hold_nxt;
            r_idle  <= w_idle_nxt;
            r_out0  <= w_out0_nxt;
            r_out1  <= w_out1_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    assign out0  = r_out0;
    assign out1  = r_out1;
    assign valid = r_valid;

endmodule

// File: tb/tb_demux1x2_stripe.sv
// Bench for demux1x2_stripe: two instances (flush after 4 and after 1 idle
// cycles) driven identically and compared every cycle with a byte-count model.
module tb_demux1x2_stripe;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in;
    logic       valid_in;
    logic [7:0] out0_a, out1_a, out0_b, out1_b;
    logic [1:0] valid_a, valid_b;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    demux1x2_stripe #(.FLUSH_CYCLES(4)) u_dut_f4 (
        .clk(clk), .reset(reset), .in(in), .valid_in(valid_in),
        .out0(out0_a), .out1(out1_a), .valid(valid_a)
    );

    demux1x2_stripe #(.FLUSH_CYCLES(1)) u_dut_f1 (
        .clk(clk), .reset(reset), .in(in), .valid_in(valid_in),
        .out0(out0_b), .out1(out1_b), .valid(valid_b)
    );

    // Reference: how many bytes are waiting (0 or 1), the waiting byte,
    // the length of the current idle run, and the last emitted lane values.
    int         flush_n [2] = '{4, 1};
    int         m_cnt   [2];
    logic [7:0] m_byte  [2];
    int         m_idle  [2];
    logic [7:0] e_out0  [2];
    logic [7:0] e_out1  [2];
    logic [1:0] e_valid [2];

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %02h, expected %02h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_step(input logic rst, input logic v, input logic [7:0] d);
        for (int m = 0; m < 2; m++) begin
            if (!rst) begin
                m_cnt[m]   = 0;
                m_idle[m]  = 0;
                e_out0[m]  = 8'h00;
                e_out1[m]  = 8'h00;
                e_valid[m] = 2'b00;
            end else begin
                e_valid[m] = 2'b00;
                if (v) begin
                    m_idle[m] = 0;
                    if (m_cnt[m] == 1) begin
                        e_out0[m]  = m_byte[m];
                        e_out1[m]  = d;
                        e_valid[m] = 2'b11;
                        m_cnt[m]   = 0;
                    end else begin
                        m_byte[m] = d;
                        m_cnt[m]  = 1;
                    end
                end else if (m_cnt[m] == 1) begin
                    m_idle[m]++;
                    if (m_idle[m] == flush_n[m]) begin
                        e_out0[m]  = m_byte[m];
                        e_out1[m]  = 8'h00;
                        e_valid[m] = 2'b01;
                        m_cnt[m]   = 0;
                        m_idle[m]  = 0;
                    end
                end
            end
        end
    endtask

    task automatic step(input logic rst, input logic v, input logic [7:0] d);
        reset    = rst;
        valid_in = v;
        in       = d;
        @(posedge clk);
        #1;
        cyc++;
        model_step(rst, v, d);
        check("f4_out0",  out0_a,        e_out0[0]);
        check("f4_out1",  out1_a,        e_out1[0]);
        check("f4_valid", {6'd0, valid_a}, {6'd0, e_valid[0]});
        check("f1_out0",  out0_b,        e_out0[1]);
        check("f1_out1",  out1_b,        e_out1[1]);
        check("f1_valid", {6'd0, valid_b}, {6'd0, e_valid[1]});
    endtask

    initial begin
        int density;
        logic       r_rst;
        logic       r_v;
        logic [7:0] r_d;

        reset    = 1'b0;
        valid_in = 1'b0;
        in       = 8'h00;

        // Reset held with traffic present: outputs stay cleared.
        step(1'b0, 1'b1, 8'hFF);
        step(1'b0, 1'b1, 8'hFF);

        // Back-to-back pairs.
        step(1'b1, 1'b1, 8'hA1);
        step(1'b1, 1'b1, 8'hB2);
        step(1'b1, 1'b1, 8'hC3);
        step(1'b1, 1'b1, 8'hD4);
        step(1'b1, 1'b0, 8'h00);

        // Pair across a short idle gap.
        step(1'b1, 1'b1, 8'h11);
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'h22);
        step(1'b1, 1'b0, 8'h00);

        // Flush after a full idle run, then the next byte restarts on lane 0.
        step(1'b1, 1'b1, 8'h33);
        repeat (4) step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'h44);
        step(1'b1, 1'b1, 8'h45);
        step(1'b1, 1'b0, 8'h00);

        // Byte arriving on the would-be flush cycle pairs instead.
        step(1'b1, 1'b1, 8'h33);
        repeat (3) step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'h55);
        step(1'b1, 1'b0, 8'h00);

        // Held byte discarded by reset.
        step(1'b1, 1'b1, 8'h44);
        step(1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'h55);
        step(1'b1, 1'b1, 8'h66);
        step(1'b1, 1'b0, 8'h00);

        // Random traffic with shifting density so that both pairing and flush occur.
        density = 90;
        for (int i = 0; i < 600; i++) begin
            if (i % 32 == 0) begin
                case ($urandom_range(0, 2))
                    0:       density = 90;
                    1:       density = 50;
                    default: density = 15;
                endcase
            end
            r_rst = ($urandom_range(0, 59) != 0);
            r_v   = ($urandom_range(0, 99) < density);
            r_d   = 8'($urandom);
            step(r_rst, r_v, r_d);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
